// File: rtl/debug_trace_buffer.sv
// debug_trace_buffer
//   Captures a per-cycle snapshot of the pipeline stage PCs and valids into a
//   circular trace memory. After arm the buffer records every cycle. A trigger
//   marks the trigger entry, and POST_TRIGGER more entries follow it. The
//   retained entries are then read out oldest-first through a valid/ready port.
//
// State table
//   state | meaning
//   IDLE  | waiting for arm; trigger and rdReady are ignored
//   ARMED | recording every cycle, waiting for trigger
//   POST  | recording the entries that follow the trigger
//   DONE  | capture frozen; entries are presented oldest-first on rdData
//
// Ports
//   clk, rst      single clock, asynchronous active-high reset
//   stageValid    per-stage valid bits (bit i = stage i)
//   stagePC       packed per-stage PCs (stage i at [i*PC_WIDTH +: PC_WIDTH])
//   arm           start a new capture (honoured only in IDLE)
//   trigger       trigger event (honoured only in ARMED)
//   clear         synchronous abort to IDLE, highest priority
//   rdReady       consumer accepts the entry on rdData
//   rdValid       rdData holds an unread entry
//   rdData        entry {stageValid, stagePC}
//   rdLast        rdData is the final entry of this capture
//   state         IDLE=0, ARMED=1, POST=2, DONE=3
//   wrapped       more than DEPTH entries were written; the oldest were lost
module debug_trace_buffer #(
  parameter int NUM_STAGES   = 5,
  parameter int PC_WIDTH     = 32,
  parameter int DEPTH        = 16,
  parameter int POST_TRIGGER = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_STAGES-1:0]                stageValid,
  input  logic [NUM_STAGES*PC_WIDTH-1:0]       stagePC,
  input  logic                                 arm,
  input  logic                                 trigger,
  input  logic                                 clear,
  input  logic                                 rdReady,
  output logic                                 rdValid,
  output logic [NUM_STAGES*(PC_WIDTH+1)-1:0]   rdData,
  output logic                                 rdLast,
  output logic [1:0]                           state,
  output logic                                 wrapped
);

  localparam int ENTRY_W = NUM_STAGES * (PC_WIDTH + 1);
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] POST_INIT = PTR_W'(POST_TRIGGER);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ENTRY_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  // Entries held while capturing; in DONE it counts the entries not yet read.
  logic [CNT_W-1:0]     r_count;
  logic [PTR_W-1:0]     r_remaining;
  logic                 r_wrapped;

  logic                 w_write;
  logic                 w_xfer;
  logic                 w_start;
  logic [CNT_W-1:0]     w_count_nxt;

  assign w_write     = ((r_state == S_ARMED) || (r_state == S_POST)) && !clear;
  assign w_xfer      = (r_state == S_DONE) && (r_count != '0) && rdReady && !clear;
  assign w_start     = (r_state == S_IDLE) && arm && !clear;
  assign w_count_nxt = (r_count == FULL) ? FULL : r_count + CNT_W'(1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (arm) w_state_nxt = S_ARMED;
        end
        S_ARMED: begin
          if (trigger) w_state_nxt = (POST_TRIGGER == 0) ? S_DONE : S_POST;
        end
        S_POST: begin
          // This cycle's write takes remaining from 1 to 0.
          if (r_remaining == PTR_W'(1)) w_state_nxt = S_DONE;
        end
        S_DONE: begin
          if (w_xfer && (r_count == CNT_W'(1))) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    state   = r_state;
    wrapped = r_wrapped;
    rdValid = (r_state == S_DONE) && (r_count != '0);
    rdLast  = (r_state == S_DONE) && (r_count == CNT_W'(1));
    rdData  = r_mem[r_rd_ptr];
  end

  // Trace memory has no reset; its contents are only observed through rdData
  // while rdValid is high.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= {stageValid, stagePC};
    end
  end

  // Pointers, counters and the wrapped flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_remaining <= '0;
      r_wrapped   <= 1'b0;
    end else begin
      if (w_start) begin
        r_wr_ptr    <= '0;
        r_count     <= '0;
        r_remaining <= '0;
        r_wrapped   <= 1'b0;
      end
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_count  <= w_count_nxt;
        if (r_count == FULL) r_wrapped <= 1'b1;
        if (r_state == S_ARMED) begin
          r_remaining <= POST_INIT;
        end else begin
          r_remaining <= r_remaining - PTR_W'(1);
        end
        // Oldest retained entry is (wrPtr - count) after this final write.
        // DEPTH is a power of two, so the subtraction wraps for free, and
        // a full buffer (count == DEPTH) truncates to 0.
        if (w_state_nxt == S_DONE) begin
          r_rd_ptr <= r_wr_ptr + PTR_W'(1) - w_count_nxt[PTR_W-1:0];
        end
      end
      if (w_xfer) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count  <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/debug_trace_buffer.md
DEBUG_TRACE_BUFFER -- requirements
Module: debug_trace_buffer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5: number of pipeline stages traced (fetch..writeback).
REQ-002 SHALL have parameter PC_WIDTH, default 32: width of each stage PC.
REQ-003 SHALL have parameter DEPTH, default 16: trace entries held; power of two, >= 2.
REQ-004 SHALL have parameter POST_TRIGGER, default 8: entries captured after the trigger entry; 0 <= POST_TRIGGER < DEPTH.
REQ-005 SHALL have port clk  input  1  the single clock.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port stageValid  input  NUM_STAGES  per-stage valid, bit i = stage i.
REQ-008 SHALL have port stagePC  input  NUM_STAGES*PC_WIDTH  packed per-stage PC, stage i at bits [i*PC_WIDTH +: PC_WIDTH].
REQ-009 SHALL have port arm  input  1  start capture.
REQ-010 SHALL have port trigger  input  1  trigger event.
REQ-011 SHALL have port clear  input  1  synchronous abort to IDLE.
REQ-012 SHALL have port rdReady  input  1  consumer accepts an entry.
REQ-013 SHALL have port rdValid  output  1  rdData holds a valid entry.
REQ-014 SHALL have port rdData  output  NUM_STAGES*(PC_WIDTH+1)  entry {stageValid, stagePC}.
REQ-015 SHALL have port rdLast  output  1  rdData is the final entry.
REQ-016 SHALL have port state  output  2  IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-017 SHALL have port wrapped  output  1  more than DEPTH entries were captured; oldest ones lost.

Function
REQ-018 SHALL implement FSM IDLE -> ARMED -> POST -> DONE -> IDLE, with all transitions on clk rising edge.
REQ-019 IDLE: arm=1 SHALL move to ARMED and set wrPtr=0, count=0, wrapped=0; trigger and rdReady SHALL be ignored.
REQ-020 ARMED and POST: every cycle SHALL write {stageValid, stagePC} to entry wrPtr, increment wrPtr mod DEPTH, and increment count saturating at DEPTH.
REQ-021 A write when count==DEPTH SHALL set wrapped=1, which holds until the next arm or reset.
REQ-022 ARMED with trigger=1: that cycle's write SHALL be the trigger entry; next state SHALL be POST with remaining=POST_TRIGGER, or DONE if POST_TRIGGER==0.
REQ-023 POST: each write SHALL decrement remaining; the write that makes remaining 0 SHALL move to DONE; trigger SHALL be ignored.
REQ-024 Total capture after trigger SHALL be exactly POST_TRIGGER+1 entries, including the trigger entry.
REQ-025 DONE: no writes; rdPtr SHALL start at (wrPtr - count) mod DEPTH, the oldest entry.
REQ-026 DONE: rdValid SHALL be 1 while unread entries remain, and rdData SHALL be the entry at rdPtr.
REQ-027 Transfer SHALL occur on rdValid && rdReady, advancing rdPtr mod DEPTH.
REQ-028 rdLast SHALL be 1 exactly when one entry remains.
REQ-029 Transfer with rdLast=1 SHALL move to IDLE.
REQ-030 While rdValid=1 and rdReady=0, rdData and rdLast SHALL hold stable.
REQ-031 arm SHALL be ignored outside IDLE.
REQ-032 clear=1 SHALL move to IDLE from any state on the next edge, with rdValid=0; clear SHALL take priority over arm, trigger and rdReady in the same cycle.
REQ-033 rdValid and rdLast SHALL be 0 in every state except DONE.

Reset
REQ-034 rst=1 SHALL immediately force state=IDLE, wrPtr=0, rdPtr=0, count=0, remaining=0, wrapped=0, rdValid=0, rdLast=0, independent of clk.
REQ-035 Trace memory contents SHALL NOT require reset; rdData is don't-care while rdValid=0.

Verification (DEPTH=8, POST_TRIGGER=3, NUM_STAGES=5)
REQ-036 Reset: assert rst mid-cycle -> state=0, rdValid=0 and wrapped=0 immediately, before the next edge.
REQ-037 Basic capture: arm; fetch PC 0x100, 0x104, with trigger on 0x108; then 0x10C, 0x110, 0x114 -> DONE after 6 entries; readout 0x100..0x114 in order; rdLast on 0x114; then IDLE.
REQ-038 Wrap: arm, 20 pre-trigger cycles (entries 0..19), trigger on entry 20 -> DONE with 8 entries 16..23, wrapped=1, first rdData=entry 16.
REQ-039 Backpressure: in DONE hold rdReady=0 for 5 cycles -> rdData unchanged, rdValid=1, rdPtr static; rdReady=1 resumes order with no loss or duplicate.
REQ-040 Abort and priority: clear during POST with remaining=2 -> IDLE next edge, rdValid=0; clear and arm together in IDLE -> stays IDLE.
REQ-041 Corners: trigger in IDLE -> ignored; trigger in the first ARMED cycle -> 4 entries; rst mid-readout -> IDLE, rdValid=0 immediately.
